sdram_rd_burst: RTL

Parametrised SDRAM burst-read engine; successor to the fixed single-geometry read block in the SDRAM controller. It sits beside the init, refresh and write engines under the top-level arbiter. It requests the bus, issues PRE/ACT/RD with configurable timing, and returns captured read data as a valid-qualified stream. It walks a linear column/row (optionally bank) address space and keeps the row open between bursts unless a refresh or row change intervenes.

---
 rtl/sdram_rd_burst.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_rd_burst.sv
`timescale 1ns/1ps
// sdram_rd_burst: SDRAM burst-read engine with PRE/ACT/RD sequencing, open-row reuse and capture.
// Define SDRAM_RD_BANK_SCAN_EN to step through all four banks on row wrap.
module sdram_rd_burst #(
    parameter int unsigned ROW_W     = 12,
    parameter int unsigned COL_W     = 9,
    parameter int unsigned DQ_W      = 16,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CAS_LAT   = 3,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_RCD     = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rd_trig,
    input  logic             rd_en,
    input  logic             ref_req,
    input  logic [DQ_W-1:0]  rd_dq,
    output logic             rd_req,
    output logic             flag_rd_end,
    output logic [3:0]       sdram_cmd,
    output logic [ROW_W-1:0] sdram_addr,
    output logic [1:0]       sdram_bank,
    output logic [DQ_W-1:0]  rd_data,
    output logic             rd_data_vld
);

    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdRd  = 4'b0101;

    localparam int unsigned     CntW     = $clog2(T_RP + T_RCD + CAS_LAT + BURST_LEN + 1);
    localparam logic [CntW-1:0] TrpLast  = CntW'(T_RP - 2);
    localparam logic [CntW-1:0] TrcdLast = CntW'(T_RCD - 2);
    localparam logic [CntW-1:0] CapFirst = CntW'(CAS_LAT - 1);
    localparam logic [CntW-1:0] CapLast  = CntW'(CAS_LAT + BURST_LEN - 2);
    localparam logic [CntW-1:0] DataLast = CntW'(CAS_LAT + BURST_LEN - 1);
    localparam logic [COL_W:0]  ColStep  = (COL_W + 1)'(BURST_LEN);

    typedef enum logic [2:0] {StIdle, StPre, StTrp, StAct, StTrcd, StRd, StData} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rd_req_q, pend_q, row_open_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [3:0]        cmd_q, cmd_d;
    logic [ROW_W-1:0]  addr_q, addr_d;
    logic [1:0]        ba_q, ba_d;
    logic [DQ_W-1:0]   rd_data_q;
    logic              vld_q, flag_q;
    logic              cap, cap_last;
    logic [COL_W:0]    col_sum;
    logic [ROW_W:0]    row_sum;

    assign col_sum = {1'b0, col_q} + ColStep;
    assign row_sum = {1'b0, row_q} + 1'b1;

`ifdef SDRAM_RD_BANK_SCAN_EN
    logic [1:0] bank_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q <= 2'b00;
        end else if (flag_q && col_sum[COL_W] && row_sum[ROW_W]) begin
            bank_q <= bank_q + 2'b01;
        end
    end
`else
    logic [1:0] bank_q;
    assign bank_q = 2'b00;
`endif

    // Capture window inside DATA: rd_dq lands CAS_LAT cycles after the RD command.
    assign cap      = (state_q == StData) && (cnt_q >= CapFirst) && (cnt_q <= CapLast);
    assign cap_last = (state_q == StData) && (cnt_q == CapLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: if (rd_en && rd_req_q) state_d = row_open_q ? StRd : StPre;
            StPre:  state_d = (T_RP > 1) ? StTrp : StAct;
            StTrp: begin
                if (cnt_q == TrpLast) state_d = StAct;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            StAct:  state_d = (T_RCD > 1) ? StTrcd : StRd;
            StTrcd: begin
                if (cnt_q == TrcdLast) state_d = StRd;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            StRd:   state_d = StData;
            StData: begin
                if (cnt_q == DataLast) state_d = StIdle;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Command outputs are registered from the next state so they align with it.
        cmd_d  = CmdNop;
        addr_d = '0;
        ba_d   = 2'b00;
        case (state_d)
            StPre: begin
                cmd_d      = CmdPre;
                addr_d[10] = 1'b1;
            end
            StAct: begin
                cmd_d  = CmdAct;
                addr_d = row_q;
                ba_d   = bank_q;
            end
            StRd: begin
                cmd_d              = CmdRd;
                addr_d[COL_W-1:0]  = col_q;
                ba_d               = bank_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rd_req_q   <= 1'b0;
            pend_q     <= 1'b0;
            row_open_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            cmd_q      <= CmdNop;
            addr_q     <= '0;
            ba_q       <= 2'b00;
            rd_data_q  <= '0;
            vld_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            vld_q   <= cap;
            flag_q  <= cap_last;
            if (cap) rd_data_q <= rd_dq;

            // Request handshake; one trigger may be parked while a burst is running.
            if (flag_q) begin
                rd_req_q <= pend_q | rd_trig;
                pend_q   <= 1'b0;
            end else if (state_q == StIdle) begin
                if (rd_en && rd_req_q)     rd_req_q <= 1'b0;
                else if (rd_trig && !rd_en) rd_req_q <= 1'b1;
            end else if (rd_trig) begin
                pend_q <= 1'b1;
            end

            if (state_d == StAct) begin
                row_open_q <= 1'b1;
            end else if (flag_q && (ref_req || col_sum[COL_W])) begin
                row_open_q <= 1'b0;
            end

            if (flag_q) begin
                col_q <= col_sum[COL_W-1:0];
                if (col_sum[COL_W]) row_q <= row_sum[ROW_W-1:0];
            end
        end
    end

    assign rd_req      = rd_req_q;
    assign flag_rd_end = flag_q;
    assign sdram_cmd   = cmd_q;
    assign sdram_addr  = addr_q;
    assign sdram_bank  = ba_q;
    assign rd_data     = rd_data_q;
    assign rd_data_vld = vld_q;

endmodule
